sram_dp_be: RTL and testbench

- Parametrised simple-dual-port word SRAM with byte enables: one write port and one read port, both usable in the same cycle.
- Adds three things a basic byte-lane SRAM lacks: a hardware clear sequencer, a read-valid handshake, and a selectable read/write collision mode.
- Serves as the table/buffer storage primitive for switch pipeline stages (match tables, action RAM, packet metadata buffers).

---
 rtl/sram_dp_be.sv | 120 ++++++++++++
 tb/tb_sram_dp_be.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sram_dp_be.sv
// sram_dp_be: simple-dual-port word SRAM with byte-lane writes, a hardware clear
//    sequencer, a registered read with a valid pulse, and a selectable collision mode.
// Latency: read data and rvalid_o appear 1 cycle after an accepted read.
//    A clear takes DEPTH cycles.
// Backpressure: none on either port. ready_o is low while clearing, and callers must
//    hold off accesses until it rises.
// Ports:
//    clk, rst                        clock and synchronous active-high reset
//    clear_i / ready_o               clear request and accept status
//    we_i, waddr_i, sel_i, wdata_i   write port (byte address, lane enables, data)
//    re_i, raddr_i                   read port (byte address)
//    rdata_o, rvalid_o               registered read result and one-cycle valid
module sram_dp_be #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = 32,
   parameter int RD_MODE    = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear_i,
   output logic                      ready_o,
   input  logic                      we_i,
   input  logic [ADDR_WIDTH-1:0]     waddr_i,
   input  logic [DATA_WIDTH/8-1:0]   sel_i,
   input  logic [DATA_WIDTH-1:0]     wdata_i,
   input  logic                      re_i,
   input  logic [ADDR_WIDTH-1:0]     raddr_i,
   output logic [DATA_WIDTH-1:0]     rdata_o,
   output logic                      rvalid_o
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int LSB   = $clog2(BYTES);
   localparam int IDXW  = $clog2(DEPTH);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

   typedef enum logic {CLEAR, READY} state_t;

   state_t                 state, state_nxt;
   logic [IDXW-1:0]        clr_cnt;
   logic [DATA_WIDTH-1:0]  mem [DEPTH];

   logic [IDXW-1:0]        widx, ridx;
   logic                   wr_acc, rd_acc;
   logic [DATA_WIDTH-1:0]  rd_word;

   // Address bits outside the word-index field are intentionally ignored.
   logic                   unused_addr;
   assign unused_addr = ^{waddr_i, raddr_i};

   assign widx = waddr_i[LSB +: IDXW];
   assign ridx = raddr_i[LSB +: IDXW];

   // Gating with rst keeps ready_o low during the reset cycle itself,
   // even before the state register has been forced.
   assign ready_o = (state == READY) && !rst;

   // A clear request in the same cycle drops both accesses.
   assign wr_acc = ready_o && we_i && !clear_i;
   assign rd_acc = ready_o && re_i && !clear_i;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= CLEAR;
      else     state <= state_nxt;
   end

   // FSM next state
   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR:   if (clr_cnt == LAST_IDX) state_nxt = READY;
         READY:   if (clear_i)             state_nxt = CLEAR;
         default: state_nxt = CLEAR;
      endcase
   end

   // The clear counter idles at 0 in READY, so every clear starts from word 0.
   always_ff @(posedge clk) begin
      if (rst)                 clr_cnt <= '0;
      else if (state == CLEAR) clr_cnt <= clr_cnt + IDXW'(1);
      else                     clr_cnt <= '0;
   end

   // Storage array: no reset. It is zeroed by the clear sequencer instead.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
         end else if (wr_acc) begin
            for (int k = 0; k < BYTES; k++) begin
               if (sel_i[k]) mem[widx][8*k +: 8] <= wdata_i[8*k +: 8];
            end
         end
      end
   end

   // Read word. In write-first mode, a same-index write is merged lane by lane.
   always_comb begin
      rd_word = mem[ridx];
      if (RD_MODE == 1 && wr_acc && (widx == ridx)) begin
         for (int k = 0; k < BYTES; k++) begin
            if (sel_i[k]) rd_word[8*k +: 8] = wdata_i[8*k +: 8];
         end
      end
   end

   // rdata_o keeps its last value between reads, and rvalid_o marks it fresh.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_o  <= '0;
         rvalid_o <= 1'b0;
      end else begin
         rvalid_o <= rd_acc;
         if (rd_acc) rdata_o <= rd_word;
      end
   end

endmodule

// File: tb/tb_sram_dp_be.sv
module tb_sram_dp_be;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear_i;
   logic        we_i;
   logic [31:0] waddr_i;
   logic [3:0]  sel_i;
   logic [31:0] wdata_i;
   logic        re_i;
   logic [31:0] raddr_i;

   logic        ready0, ready1, rvalid0, rvalid1;
   logic [31:0] rdata0, rdata1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Read-old instance
   sram_dp_be #(.DATA_WIDTH(32), .DEPTH(256), .ADDR_WIDTH(32), .RD_MODE(0)) dut0 (
      .clk(clk), .rst(rst), .clear_i(clear_i), .ready_o(ready0),
      .we_i(we_i), .waddr_i(waddr_i), .sel_i(sel_i), .wdata_i(wdata_i),
      .re_i(re_i), .raddr_i(raddr_i), .rdata_o(rdata0), .rvalid_o(rvalid0)
   );

   // Write-first instance, driven by the same stimulus
   sram_dp_be #(.DATA_WIDTH(32), .DEPTH(256), .ADDR_WIDTH(32), .RD_MODE(1)) dut1 (
      .clk(clk), .rst(rst), .clear_i(clear_i), .ready_o(ready1),
      .we_i(we_i), .waddr_i(waddr_i), .sel_i(sel_i), .wdata_i(wdata_i),
      .re_i(re_i), .raddr_i(raddr_i), .rdata_o(rdata1), .rvalid_o(rvalid1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      we_i = 1'b1; waddr_i = a; wdata_i = d; sel_i = s;
      step();
      we_i = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      re_i = 1'b1; raddr_i = a;
      step();
      re_i = 1'b0;
      chk({tag, "_rvalid0"}, {31'd0, rvalid0}, 32'd1);
      chk({tag, "_rvalid1"}, {31'd0, rvalid1}, 32'd1);
      chk({tag, "_rdata0"}, rdata0, exp);
      chk({tag, "_rdata1"}, rdata1, exp);
   endtask

   // Count cycles until both instances report ready, with a bounded wait.
   // Also counts any rvalid pulses seen during the wait.
   task automatic wait_ready(output int n, output int rv);
      n = 0; rv = 0;
      while (!(ready0 && ready1) && n < 1000) begin
         step();
         n++;
         if (rvalid0 || rvalid1) rv++;
      end
   endtask

   int n, rv;

   initial begin
      rst = 1'b1; clear_i = 1'b0; we_i = 1'b0; waddr_i = '0; sel_i = '0;
      wdata_i = '0; re_i = 1'b0; raddr_i = '0;

      // 1. Reset, then clear with a read held pending
      step();
      chk("rst_ready0", {31'd0, ready0}, 32'd0);
      chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
      chk("rst_rdata0", rdata0, 32'h0);
      chk("rst_rdata1", rdata1, 32'h0);
      rst = 1'b0; re_i = 1'b1; raddr_i = 32'h3FC;
      wait_ready(n, rv);
      chk("reset_clear_cycles", n, 32'd256);
      chk("reset_clear_rvalid", rv, 32'd0);
      rd("read_3fc", 32'h3FC, 32'h0000_0000);
      step();
      chk("idle_rvalid0", {31'd0, rvalid0}, 32'd0);
      chk("idle_rdata_hold", rdata0, 32'h0);

      // 2. Byte-lane writes
      wr(32'h010, 32'hAABBCCDD, 4'b1111);
      wr(32'h010, 32'h11223344, 4'b0101);
      rd("lane_010", 32'h010, 32'hAA22CC44);
      rd("lane_013", 32'h013, 32'hAA22CC44);
      step();
      chk("hold_rvalid1", {31'd0, rvalid1}, 32'd0);
      chk("hold_rdata1", rdata1, 32'hAA22CC44);

      // 3. Address wrap
      wr(32'h404, 32'hDEADBEEF, 4'b1111);
      rd("wrap_004", 32'h004, 32'hDEADBEEF);

      // 4. Collision in the same cycle
      wr(32'h020, 32'h01020304, 4'b1111);
      we_i = 1'b1; waddr_i = 32'h020; sel_i = 4'b0011; wdata_i = 32'hFFFFFFFF;
      re_i = 1'b1; raddr_i = 32'h020;
      step();
      we_i = 1'b0; re_i = 1'b0;
      chk("coll_rvalid0", {31'd0, rvalid0}, 32'd1);
      chk("coll_mode0", rdata0, 32'h01020304);
      chk("coll_mode1", rdata1, 32'h0102FFFF);
      rd("coll_after", 32'h020, 32'h0102FFFF);
      // A write and a read to different words do not interact
      we_i = 1'b1; waddr_i = 32'h030; sel_i = 4'b1111; wdata_i = 32'h99999999;
      re_i = 1'b1; raddr_i = 32'h010;
      step();
      we_i = 1'b0; re_i = 1'b0;
      chk("indep_mode0", rdata0, 32'hAA22CC44);
      chk("indep_mode1", rdata1, 32'hAA22CC44);
      rd("indep_030", 32'h030, 32'h99999999);

      // 5. Streaming reads, then a clear that drops a same-cycle write
      wr(32'h008, 32'h55667788, 4'b1111);
      re_i = 1'b1; raddr_i = 32'h000;
      step();
      chk("stream0_v", {31'd0, rvalid0}, 32'd1);
      chk("stream0_d", rdata0, 32'h0);
      raddr_i = 32'h004;
      step();
      chk("stream1_v", {31'd0, rvalid0}, 32'd1);
      chk("stream1_d", rdata0, 32'hDEADBEEF);
      raddr_i = 32'h008;
      step();
      chk("stream2_v", {31'd0, rvalid1}, 32'd1);
      chk("stream2_d", rdata1, 32'h55667788);
      re_i = 1'b0;
      step();
      chk("stream_end_v", {31'd0, rvalid0}, 32'd0);

      clear_i = 1'b1; we_i = 1'b1; waddr_i = 32'h000; sel_i = 4'b1111;
      wdata_i = 32'hCAFEF00D; re_i = 1'b1; raddr_i = 32'h004;
      step();
      clear_i = 1'b0; we_i = 1'b0; re_i = 1'b0;
      chk("clr_ready", {31'd0, ready0}, 32'd0);
      chk("clr_read_dropped", {31'd0, rvalid0}, 32'd0);
      chk("clr_rdata_hold", rdata0, 32'h55667788);
      wait_ready(n, rv);
      chk("clear_cycles", n, 32'd256);
      chk("clear_rvalid", rv, 32'd0);
      rd("cleared_000", 32'h000, 32'h0);
      rd("cleared_004", 32'h004, 32'h0);
      rd("cleared_008", 32'h008, 32'h0);
      rd("cleared_010", 32'h010, 32'h0);

      // 6. Reset asserted during a clear
      wr(32'h00C, 32'h12345678, 4'b1111);
      rd("pre_rst_00c", 32'h00C, 32'h12345678);
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      repeat (100) step();
      rst = 1'b1;
      step();
      chk("midrst_ready", {31'd0, ready1}, 32'd0);
      chk("midrst_rvalid", {31'd0, rvalid0}, 32'd0);
      chk("midrst_rdata0", rdata0, 32'h0);
      chk("midrst_rdata1", rdata1, 32'h0);
      rst = 1'b0;
      wait_ready(n, rv);
      chk("midrst_clear_cycles", n, 32'd256);
      rd("midrst_00c", 32'h00C, 32'h0);
      rd("midrst_3fc", 32'h3FC, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
